magic_device_reader: RTL

- Requester-side engine for the magic-device read channel: drives read_select/read_ready toward the device and consumes read_valid/read_data.
- Accepts a burst command (start select plus count), issues one read per select, and buffers results in a small response FIFO.
- Adds a per-read timeout so the downstream consumer (probe/debug logic in the SoC harness) never hangs on a silent device.

---
 rtl/magic_device_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/magic_device_reader.sv
// Requester-side read engine for the magic device: issues burst reads one select at a time,
// buffers responses in a small FIFO and converts a silent device into a timeout error entry.
module magic_device_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] cmd_select,
    input  logic [7:0]  cmd_count,
    output logic [11:0] read_select,
    output logic        read_ready,
    input  logic        read_valid,
    input  logic [63:0] read_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        resp_last,
    output logic        busy
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e          state_q;
    logic [11:0]     sel_q;
    logic [7:0]      remain_q;
    logic [TW-1:0]   timer_q;
    logic            rd_ready_q;

    logic [63:0]     mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] err_q;
    logic [FIFO_DEPTH-1:0] last_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic            complete;
    logic            timed_out;
    logic            push;
    logic            pop;
    logic [63:0]     push_data;
    logic            push_err;
    logic            push_last;
    logic            not_full_d;

    always_comb begin
        complete   = rd_ready_q && read_valid;
        timed_out  = TIMEOUT_EN && rd_ready_q && !read_valid && (timer_q == TIMER_LAST);
        push       = complete || timed_out;
        push_data  = complete ? read_data : 64'hFFFF_FFFF_FFFF_FFFF;
        push_err   = !complete;
        push_last  = complete ? (remain_q == 8'd0) : 1'b1;
        pop        = (count_q != '0) && resp_ready;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        // read_ready is registered, so it must look at the post-edge occupancy
        not_full_d = (count_d != CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            remain_q   <= '0;
            timer_q    <= '0;
            rd_ready_q <= 1'b0;
        end else begin
            rd_ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        sel_q      <= cmd_select;
                        remain_q   <= cmd_count;
                        timer_q    <= '0;
                        state_q    <= StIssue;
                        rd_ready_q <= not_full_d;
                    end
                end
                StIssue: begin
                    if (complete) begin
                        if (remain_q == 8'd0) begin
                            state_q <= StIdle;
                        end else begin
                            sel_q      <= sel_q + 12'd1;
                            remain_q   <= remain_q - 8'd1;
                            timer_q    <= '0;
                            rd_ready_q <= not_full_d;
                        end
                    end else if (timed_out) begin
                        state_q <= StDrain;
                    end else begin
                        rd_ready_q <= not_full_d;
                        // timer only runs while a request is actually outstanding
                        if (rd_ready_q) begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                end
                StDrain: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
            last_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]  <= push_data;
                err_q[wr_ptr_q]  <= push_err;
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign read_select = sel_q;
    assign read_ready  = rd_ready_q;
    assign resp_valid  = (count_q != '0);
    assign resp_data   = mem_q[rd_ptr_q];
    assign resp_err    = err_q[rd_ptr_q];
    assign resp_last   = last_q[rd_ptr_q];
    assign busy        = (state_q != StIdle) || (count_q != '0);

endmodule
